data_mem_responder: RTL and testbench

//  Responder for the core's data-memory port: decodes the M-stage address, serves word RAM and MMIO.

---
 rtl/data_mem_responder.sv | 151 +++++++++++++++
 tb/tb_data_mem_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory responder for the core's M stage. Decodes the byte address
//   into word RAM, an MMIO block or unmapped space. Loads are combinational
//   (zero wait states); stores commit on the rising edge with MemWrite=1.
//
//   MMIO block (word offsets from MMIO_BASE):
//     0x00 LED    RW     low LED_W bits, read zero-extended
//     0x04 SW     RO     two-FF synchronised switches, read zero-extended
//     0x08 CYCLE  RW     free-running counter, any write loads 0
//     0x0C CMP    RW     compare value for the match flag
//     0x10 STATUS R/W1C  bit0 = sticky match flag
//     0x14-0x1C          read 0, writes ignored (not errors)
//
// Ports
//   CLK        in   1      clock, all state on rising edge
//   Reset      in   1      asynchronous, active-high reset
//   MemWrite   in   1      store strobe from core M stage
//   Addr       in   32     byte address; Addr[1:0] ignored
//   WriteData  in   32     store data (whole word only)
//   ReadData   out  32     load data, combinational from Addr
//   SW         in   SW_W   asynchronous switch inputs
//   LED        out  LED_W  LED register
//   TimerIrq   out  1      sticky timer-match flag (= STATUS[0])
//   AccessErr  out  1      sticky: store to unmapped address since reset

module data_mem_responder #(
    parameter logic [31:0] RAM_BASE  = 32'h0000_0800,
    parameter int          RAM_AW    = 8,
    parameter logic [31:0] MMIO_BASE = 32'h0000_0C00,
    parameter int          LED_W     = 16,
    parameter int          SW_W      = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemWrite,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    input  logic [SW_W-1:0]   SW,
    output logic [LED_W-1:0]  LED,
    output logic              TimerIrq,
    output logic              AccessErr
);

    localparam int          RAM_WORDS = 1 << RAM_AW;
    localparam logic [2:0]  OFF_LED    = 3'd0;
    localparam logic [2:0]  OFF_SW     = 3'd1;
    localparam logic [2:0]  OFF_CYCLE  = 3'd2;
    localparam logic [2:0]  OFF_CMP    = 3'd3;
    localparam logic [2:0]  OFF_STATUS = 3'd4;
    localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

    logic [31:0]       ramMem [0:RAM_WORDS-1];
    logic [LED_W-1:0]  ledReg;
    logic [SW_W-1:0]   swMeta;
    logic [SW_W-1:0]   swSync;
    logic [31:0]       cycleCnt;
    logic [31:0]       cmpReg;
    logic              matchFlag;
    logic              accessErrReg;

    logic              ramSel;
    logic              mmioSel;
    logic [RAM_AW-1:0] ramIdx;
    logic [2:0]        mmioOff;
    logic              mmioWr;
    logic              unusedBits;

    // RAM_BASE is aligned to the RAM size and MMIO_BASE to its 32-byte
    // window, so both decodes reduce to an upper-bit compare.
    assign ramSel  = (Addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);
    assign mmioSel = (Addr[31:5] == MMIO_BASE[31:5]);
    assign ramIdx  = Addr[RAM_AW+1:2];
    assign mmioOff = Addr[4:2];
    assign mmioWr  = MemWrite && mmioSel;

    // Byte-lane bits are ignored; only whole-word accesses exist.
    assign unusedBits = ^Addr[1:0];

    // RAM is not reset. Gating on Reset drops a store that coincides with
    // reset assertion so RAM cannot change while the MMIO side is cleared.
    always_ff @(posedge CLK) begin
        if (MemWrite && ramSel && !Reset) begin
            ramMem[ramIdx] <= WriteData;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ledReg       <= '0;
            swMeta       <= '0;
            swSync       <= '0;
            cycleCnt     <= '0;
            cmpReg       <= 32'hFFFF_FFFF;
            matchFlag    <= 1'b0;
            accessErrReg <= 1'b0;
        end else begin
            swMeta <= SW;
            swSync <= swMeta;

            // A CYCLE write takes priority over the increment.
            if (mmioWr && mmioOff == OFF_CYCLE) begin
                cycleCnt <= '0;
            end else begin
                cycleCnt <= cycleCnt + 32'd1;
            end

            if (mmioWr && mmioOff == OFF_LED) begin
                ledReg <= WriteData[LED_W-1:0];
            end

            if (mmioWr && mmioOff == OFF_CMP) begin
                cmpReg <= WriteData;
            end

            // Compare uses the pre-increment count; a match beats a
            // same-edge write-1-to-clear.
            if (cycleCnt == cmpReg) begin
                matchFlag <= 1'b1;
            end else if (mmioWr && mmioOff == OFF_STATUS && WriteData[0]) begin
                matchFlag <= 1'b0;
            end

            // Only stores flag errors: the core drives Addr for non-memory ops.
            if (MemWrite && !ramSel && !mmioSel) begin
                accessErrReg <= 1'b1;
            end
        end
    end

    always_comb begin
        ReadData = UNMAPPED_DATA;
        if (ramSel) begin
            ReadData = ramMem[ramIdx];
        end else if (mmioSel) begin
            case (mmioOff)
                OFF_LED:    ReadData = 32'(ledReg);
                OFF_SW:     ReadData = 32'(swSync);
                OFF_CYCLE:  ReadData = cycleCnt;
                OFF_CMP:    ReadData = cmpReg;
                OFF_STATUS: ReadData = {31'd0, matchFlag};
                default:    ReadData = 32'd0;
            endcase
        end
    end

    assign LED       = ledReg;
    assign TimerIrq  = matchFlag;
    assign AccessErr = accessErrReg;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed bench for data_mem_responder: reset values, RAM store/load
//   timing and boundaries, LED/SW/CYCLE/CMP/STATUS behaviour, counter wrap,
//   unmapped reads and stores, and asynchronous reset.

module tb_data_mem_responder;

    logic        CLK;
    logic        Reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [15:0] SW;
    logic [15:0] LED;
    logic        TimerIrq;
    logic        AccessErr;

    int totalChecks = 0;
    int badChecks   = 0;

    data_mem_responder dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .SW        (SW),
        .LED       (LED),
        .TimerIrq  (TimerIrq),
        .AccessErr (AccessErr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive a bus cycle after the falling edge; the preceding rising edge
    // has already committed the previous cycle's store.
    task automatic setBus(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        MemWrite  = we;
        Addr      = a;
        WriteData = d;
        #1;
    endtask

    initial begin
        Reset     = 1'b1;
        MemWrite  = 1'b0;
        Addr      = 32'h0000_0C0C;
        WriteData = 32'd0;
        SW        = 16'd0;

        // Reset state
        #3;
        checkVal("rst_cmp", ReadData, 32'hFFFF_FFFF);
        Addr = 32'h0000_0C00;
        #1;
        checkVal("rst_led_rd", ReadData, 32'd0);
        checkVal("rst_led", {16'd0, LED}, 32'd0);
        checkVal("rst_irq", {31'd0, TimerIrq}, 32'd0);
        checkVal("rst_err", {31'd0, AccessErr}, 32'd0);
        #8;
        Reset = 1'b0;

        // RAM: same-cycle read returns old value, new value next cycle
        setBus(1'b1, 32'h0000_0804, 32'h1111_1111);
        setBus(1'b1, 32'h0000_0804, 32'h1234_5678);
        checkVal("ram_old", ReadData, 32'h1111_1111);
        setBus(1'b0, 32'h0000_0804, 32'd0);
        checkVal("ram_new", ReadData, 32'h1234_5678);

        // RAM boundaries: first and last words are distinct
        setBus(1'b1, 32'h0000_0800, 32'hAAAA_0000);
        setBus(1'b1, 32'h0000_0BFC, 32'h5555_FFFF);
        setBus(1'b0, 32'h0000_0800, 32'd0);
        checkVal("ram_first", ReadData, 32'hAAAA_0000);
        setBus(1'b0, 32'h0000_0BFC, 32'd0);
        checkVal("ram_last", ReadData, 32'h5555_FFFF);
        setBus(1'b0, 32'h0000_0806, 32'd0);
        checkVal("ram_lowbits", ReadData, 32'h1234_5678);

        // LED
        setBus(1'b1, 32'h0000_0C00, 32'h0000_00A5);
        setBus(1'b0, 32'h0000_0C00, 32'd0);
        checkVal("led_a5", {16'd0, LED}, 32'h0000_00A5);
        checkVal("led_rd", ReadData, 32'h0000_00A5);
        setBus(1'b1, 32'h0000_0C00, 32'hFFFF_1234);
        setBus(1'b0, 32'h0000_0C00, 32'd0);
        checkVal("led_trunc", ReadData, 32'h0000_1234);

        // SW read-only and two-edge synchroniser latency
        setBus(1'b1, 32'h0000_0C04, 32'hFFFF_FFFF);
        setBus(1'b0, 32'h0000_0C04, 32'd0);
        checkVal("sw_ro", ReadData, 32'd0);
        checkVal("sw_wr_led", {16'd0, LED}, 32'h0000_1234);
        SW = 16'h3C0F;
        #1;
        checkVal("sw_e0", ReadData, 32'd0);
        setBus(1'b0, 32'h0000_0C04, 32'd0);
        checkVal("sw_e1", ReadData, 32'd0);
        setBus(1'b0, 32'h0000_0C04, 32'd0);
        checkVal("sw_e2", ReadData, 32'h0000_3C0F);

        // Timer: CMP=5, CYCLE write loads 0, flag rises after CYCLE==5
        setBus(1'b1, 32'h0000_0C0C, 32'd5);
        setBus(1'b1, 32'h0000_0C08, 32'h0000_007B);
        checkVal("cmp_rd", ReadData != 32'd0 ? 32'd1 : 32'd0, 32'd1);
        setBus(1'b0, 32'h0000_0C08, 32'd0);
        checkVal("cyc_zero", ReadData, 32'd0);
        checkVal("irq_pre", {31'd0, TimerIrq}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            setBus(1'b0, 32'h0000_0C08, 32'd0);
            checkVal($sformatf("cyc_%0d", i), ReadData, 32'(i));
        end
        // CYCLE now holds 5: W1C on the match edge, set wins
        setBus(1'b1, 32'h0000_0C10, 32'd1);
        checkVal("stat_pre", ReadData, 32'd0);
        setBus(1'b0, 32'h0000_0C10, 32'd0);
        checkVal("stat_set_wins", ReadData, 32'd1);
        checkVal("irq_set", {31'd0, TimerIrq}, 32'd1);
        setBus(1'b1, 32'h0000_0C10, 32'd0);
        setBus(1'b0, 32'h0000_0C10, 32'd0);
        checkVal("w1c_zero_keeps", ReadData, 32'd1);
        setBus(1'b1, 32'h0000_0C10, 32'hFFFF_FFFF);
        setBus(1'b0, 32'h0000_0C10, 32'd0);
        checkVal("w1c_clear", ReadData, 32'd0);
        checkVal("irq_clear", {31'd0, TimerIrq}, 32'd0);

        // CYCLE wrap via backdoor preset, then free-run
        setBus(1'b0, 32'h0000_0C08, 32'd0);
        force dut.cycleCnt = 32'hFFFF_FFFE;
        #1;
        release dut.cycleCnt;
        #1;
        checkVal("wrap_fe", ReadData, 32'hFFFF_FFFE);
        setBus(1'b0, 32'h0000_0C08, 32'd0);
        checkVal("wrap_ff", ReadData, 32'hFFFF_FFFF);
        setBus(1'b0, 32'h0000_0C08, 32'd0);
        checkVal("wrap_0", ReadData, 32'd0);
        setBus(1'b0, 32'h0000_0C08, 32'd0);
        checkVal("wrap_1", ReadData, 32'd1);

        // Reserved MMIO offsets and unmapped space
        setBus(1'b1, 32'h0000_0C14, 32'h0000_0007);
        setBus(1'b0, 32'h0000_0C14, 32'd0);
        checkVal("rsvd_rd", ReadData, 32'd0);
        checkVal("rsvd_noerr", {31'd0, AccessErr}, 32'd0);
        setBus(1'b0, 32'h0000_2000, 32'd0);
        checkVal("unmap_rd", ReadData, 32'hDEAD_BEEF);
        setBus(1'b0, 32'h0000_0C20, 32'd0);
        checkVal("mmio_end", ReadData, 32'hDEAD_BEEF);
        setBus(1'b0, 32'h0000_07FC, 32'd0);
        checkVal("ram_below", ReadData, 32'hDEAD_BEEF);
        checkVal("rd_noerr", {31'd0, AccessErr}, 32'd0);
        setBus(1'b1, 32'h0000_2000, 32'h0000_0001);
        setBus(1'b0, 32'h0000_0000, 32'd0);
        checkVal("err_set", {31'd0, AccessErr}, 32'd1);
        setBus(1'b0, 32'h0000_0C00, 32'd0);
        checkVal("err_sticky", {31'd0, AccessErr}, 32'd1);

        // Asynchronous reset mid-cycle, no clock edge in between
        Addr  = 32'h0000_0C0C;
        Reset = 1'b1;
        #1;
        checkVal("arst_err", {31'd0, AccessErr}, 32'd0);
        checkVal("arst_led", {16'd0, LED}, 32'd0);
        checkVal("arst_cmp", ReadData, 32'hFFFF_FFFF);
        @(negedge CLK);
        Reset = 1'b0;

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
